// File: rtl/mandel_pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// mandel_pixel_dispatcher : walks a frame of complex coordinates and deals them
// round-robin to NUM_CH iterator channels, tracking pixels still in flight.
// Revision: 1.0
// ============================================================================
module mandel_pixel_dispatcher #(
    parameter int WIDTH  = 27,
    parameter int H_PIX  = 640,
    parameter int V_PIX  = 480,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 19,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [WIDTH-1:0]         xstart_i,
    input  logic [WIDTH-1:0]         ystart_i,
    input  logic [WIDTH-1:0]         xstep_i,
    input  logic [WIDTH-1:0]         ystep_i,
    output logic [NUM_CH-1:0]        ch_valid_o,
    input  logic [NUM_CH-1:0]        ch_ready_i,
    output logic [NUM_CH*WIDTH-1:0]  ch_cx_o,
    output logic [NUM_CH*WIDTH-1:0]  ch_cy_o,
    output logic [NUM_CH*ADDR_W-1:0] ch_addr_o,
    input  logic [NUM_CH-1:0]        ch_retire_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [CNT_W-1:0]         frame_cycles_o,
    output logic                     err_o
);

    localparam int PX_W = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OW   = ADDR_W + 1;
    localparam int SW   = OW + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DRAIN    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    xstart_q, xstart_d, xstep_q, xstep_d, ystep_q, ystep_d;
    logic [WIDTH-1:0]    cx_cur_q, cx_cur_d, cy_cur_q, cy_cur_d;
    logic [PX_W-1:0]     px_q, px_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [RR_W-1:0]     rr_q, rr_d;
    logic [NUM_CH-1:0]   valid_q, valid_d;
    logic [WIDTH-1:0]    slot_cx_q [NUM_CH];
    logic [WIDTH-1:0]    slot_cx_d [NUM_CH];
    logic [WIDTH-1:0]    slot_cy_q [NUM_CH];
    logic [WIDTH-1:0]    slot_cy_d [NUM_CH];
    logic [ADDR_W-1:0]   slot_addr_q [NUM_CH];
    logic [ADDR_W-1:0]   slot_addr_d [NUM_CH];
    logic [OW-1:0]       out_q, out_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, fc_q, fc_d, cnt_inc;
    logic                err_q, err_d;

    logic [NUM_CH-1:0]   hs, loadable;
    logic                found;
    logic [RR_W-1:0]     pick, idx;
    logic [SW-1:0]       n_hs, n_ret, sum;

    assign hs       = valid_q & ch_ready_i;
    assign loadable = ~valid_q | hs;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // First loadable slot at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = RR_W'((int'(rr_q) + k) % NUM_CH);
            if (!found && loadable[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        n_hs  = '0;
        n_ret = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_hs  = n_hs  + SW'(hs[i]);
            n_ret = n_ret + SW'(ch_retire_i[i]);
        end
        sum = {1'b0, out_q} + n_hs;
    end

    always_comb begin
        state_d     = state_q;
        xstart_d    = xstart_q;
        xstep_d     = xstep_q;
        ystep_d     = ystep_q;
        cx_cur_d    = cx_cur_q;
        cy_cur_d    = cy_cur_q;
        px_d        = px_q;
        addr_d      = addr_q;
        rr_d        = rr_q;
        valid_d     = valid_q & ~hs;
        slot_cx_d   = slot_cx_q;
        slot_cy_d   = slot_cy_q;
        slot_addr_d = slot_addr_q;
        cnt_d       = cnt_q;
        fc_d        = fc_q;
        err_d       = err_q;

        // Underflow saturates and flags; a retire with nothing in flight is a protocol slip.
        if (sum < n_ret) begin
            out_d = '0;
            err_d = 1'b1;
        end else begin
            out_d = OW'(sum - n_ret);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    xstart_d = xstart_i;
                    xstep_d  = xstep_i;
                    ystep_d  = ystep_i;
                    cx_cur_d = xstart_i;
                    cy_cur_d = ystart_i;
                    px_d     = '0;
                    addr_d   = '0;
                    rr_d     = '0;
                    cnt_d    = '0;
                    out_d    = '0;
                    state_d  = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                cnt_d = cnt_inc;
                if (found) begin
                    valid_d[pick]     = 1'b1;
                    slot_cx_d[pick]   = cx_cur_q;
                    slot_cy_d[pick]   = cy_cur_q;
                    slot_addr_d[pick] = addr_q;
                    rr_d   = (pick == RR_W'(NUM_CH - 1)) ? '0 : pick + RR_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                    if (px_q == PX_W'(H_PIX - 1)) begin
                        px_d     = '0;
                        cx_cur_d = xstart_q;
                        cy_cur_d = cy_cur_q + ystep_q;
                        if (addr_q == ADDR_W'(H_PIX * V_PIX - 1)) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        px_d     = px_q + PX_W'(1);
                        cx_cur_d = cx_cur_q + xstep_q;
                    end
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_inc;
                if (valid_q == '0 && out_q == '0) begin
                    fc_d    = cnt_inc;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i && (state_q == S_DISPATCH || state_q == S_DRAIN)) begin
            valid_d = '0;
            out_d   = '0;
            fc_d    = fc_q;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            xstart_q    <= '0;
            xstep_q     <= '0;
            ystep_q     <= '0;
            cx_cur_q    <= '0;
            cy_cur_q    <= '0;
            px_q        <= '0;
            addr_q      <= '0;
            rr_q        <= '0;
            valid_q     <= '0;
            slot_cx_q   <= '{default: '0};
            slot_cy_q   <= '{default: '0};
            slot_addr_q <= '{default: '0};
            out_q       <= '0;
            cnt_q       <= '0;
            fc_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            xstart_q    <= xstart_d;
            xstep_q     <= xstep_d;
            ystep_q     <= ystep_d;
            cx_cur_q    <= cx_cur_d;
            cy_cur_q    <= cy_cur_d;
            px_q        <= px_d;
            addr_q      <= addr_d;
            rr_q        <= rr_d;
            valid_q     <= valid_d;
            slot_cx_q   <= slot_cx_d;
            slot_cy_q   <= slot_cy_d;
            slot_addr_q <= slot_addr_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            fc_q        <= fc_d;
            err_q       <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign ch_cx_o[g*WIDTH +: WIDTH]     = slot_cx_q[g];
        assign ch_cy_o[g*WIDTH +: WIDTH]     = slot_cy_q[g];
        assign ch_addr_o[g*ADDR_W +: ADDR_W] = slot_addr_q[g];
    end

    assign ch_valid_o     = valid_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign frame_cycles_o = fc_q;
    assign err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mandel_pixel_dispatcher.sv
`default_nettype none
// Bench for mandel_pixel_dispatcher on a 4x3 frame with two channels; a queue of
// model pixels is filled at each start and matched against observed handshakes.
module tb_mandel_pixel_dispatcher;

    localparam int W    = 27;
    localparam int H    = 4;
    localparam int V    = 3;
    localparam int NC   = 2;
    localparam int AW   = 8;
    localparam int CW   = 32;
    localparam int NPIX = H * V;

    typedef struct {
        int            ch;
        logic [AW-1:0] addr;
        logic [W-1:0]  cx;
        logic [W-1:0]  cy;
        int            cyc;
    } pix_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [W-1:0]      xstart = '0, ystart = '0, xstep = '0, ystep = '0;
    logic [NC-1:0]     ch_valid;
    logic [NC-1:0]     ch_ready = '1;
    logic [NC*W-1:0]   ch_cx, ch_cy;
    logic [NC*AW-1:0]  ch_addr;
    logic [NC-1:0]     ch_retire, ret_auto = '0, ret_man = '0;
    logic              busy, done, err;
    logic [CW-1:0]     frame_cycles;

    pix_t              obs_q[$];
    pix_t              exp_q[$];
    int                vectors = 0;
    int                miscompares = 0;
    int                cyc = 0;
    int                done_cnt = 0;
    int                done_cyc = -1;
    logic              auto_en = 1'b0;
    logic [NC-1:0]     hs_cap = '0;

    assign ch_retire = ret_auto | ret_man;

    mandel_pixel_dispatcher #(
        .WIDTH(W), .H_PIX(H), .V_PIX(V), .NUM_CH(NC), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start), .abort_i(abort),
        .xstart_i(xstart), .ystart_i(ystart), .xstep_i(xstep), .ystep_i(ystep),
        .ch_valid_o(ch_valid), .ch_ready_i(ch_ready),
        .ch_cx_o(ch_cx), .ch_cy_o(ch_cy), .ch_addr_o(ch_addr),
        .ch_retire_i(ch_retire), .busy_o(busy), .done_o(done),
        .frame_cycles_o(frame_cycles), .err_o(err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        pix_t p;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (ch_valid[i] && ch_ready[i]) begin
                    p.ch   = i;
                    p.addr = ch_addr[i*AW +: AW];
                    p.cx   = ch_cx[i*W +: W];
                    p.cy   = ch_cy[i*W +: W];
                    p.cyc  = cyc;
                    obs_q.push_back(p);
                end
            end
            hs_cap = ch_valid & ch_ready;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Iterator model: each accepted pixel retires one cycle after its handshake.
    initial forever begin
        @(posedge clk);
        #1;
        ret_auto = auto_en ? hs_cap : '0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void push_frame(input logic [W-1:0] xs, ys, xst, yst);
        pix_t p;
        exp_q.delete();
        for (int a = 0; a < NPIX; a++) begin
            p.ch   = a % NC;
            p.addr = AW'(a);
            p.cx   = xs + W'(a % H) * xst;
            p.cy   = ys + W'(a / H) * yst;
            p.cyc  = 0;
            exp_q.push_back(p);
        end
    endfunction

    task automatic start_frame(output int t0);
        obs_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        start = 1'b1;
        t0 = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        for (int k = 0; k < budget && done_cnt == 0; k++) tick(1);
        ok = (done_cnt != 0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        vectors++;
        if (ch_valid !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || frame_cycles !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b err=%b fc=%0d, required 0 0 0 0 0",
                     ch_valid, busy, done, err, frame_cycles);
        end
        vectors++;
        if (ch_cx !== '0 || ch_cy !== '0 || ch_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_data: cx=%h cy=%h addr=%h, required all zero", ch_cx, ch_cy, ch_addr);
        end
    endtask

    task automatic test_frame;
        int t0;
        bit ok;
        pix_t e;
        xstart = 27'h7000000; xstep = 27'h0080000; ystart = '0; ystep = 27'h0100000;
        ch_ready = '1; auto_en = 1'b1;
        push_frame(xstart, ystart, xstep, ystep);
        start_frame(t0);
        vectors++;
        if (busy !== 1'b1 || ch_valid !== '0) begin
            miscompares++;
            $display("FAIL frame_cycle1: busy=%b valid=%b, required busy=1 valid=00", busy, ch_valid);
        end
        tick(1);
        vectors++;
        if (ch_valid[0] !== 1'b1 || ch_addr[0 +: AW] !== '0) begin
            miscompares++;
            $display("FAIL frame_first_valid: valid=%b addr0=%0d, required valid[0]=1 addr0=0", ch_valid, ch_addr[0 +: AW]);
        end
        wait_done(40, ok);
        vectors++;
        if (!ok || done_cyc - t0 != 16) begin
            miscompares++;
            $display("FAIL frame_done_cycle: got cycle %0d (seen=%0b), required 16", done_cyc - t0, ok);
        end
        vectors++;
        if (frame_cycles !== 32'd15) begin
            miscompares++;
            $display("FAIL frame_cycles: got %0d, required 15", frame_cycles);
        end
        tick(3);
        vectors++;
        if (done_cnt != 1 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_after: done pulses=%0d busy=%b err=%b, required 1 0 0", done_cnt, busy, err);
        end
        vectors++;
        if (obs_q.size() != NPIX) begin
            miscompares++;
            $display("FAIL frame_count: got %0d handshakes, required %0d", obs_q.size(), NPIX);
        end else begin
            vectors++;
            if (obs_q[4].cx !== 27'h7000000 || obs_q[4].cy !== 27'h0100000) begin
                miscompares++;
                $display("FAIL frame_addr4: cx=%h cy=%h, required 7000000 0100000", obs_q[4].cx, obs_q[4].cy);
            end
            for (int i = 0; i < NPIX; i++) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_q[i].addr !== e.addr || obs_q[i].ch != e.ch || obs_q[i].cx !== e.cx || obs_q[i].cy !== e.cy) begin
                    miscompares++;
                    $display("FAIL frame_pix%0d: ch=%0d addr=%0d cx=%h cy=%h, required ch=%0d addr=%0d cx=%h cy=%h",
                             i, obs_q[i].ch, obs_q[i].addr, obs_q[i].cx, obs_q[i].cy, e.ch, e.addr, e.cx, e.cy);
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        int t0;
        auto_en = 1'b0; ch_ready = '1;
        start_frame(t0);
        tick(4);
        reset = 1'b1;
        tick(1);
        vectors++;
        if (ch_valid !== '0 || busy !== 1'b0 || frame_cycles !== '0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_hold: valid=%b busy=%b fc=%0d done=%b, required 00 0 0 0", ch_valid, busy, frame_cycles, done);
        end
        tick(2);
        reset = 1'b0;
        tick(1);
        vectors++;
        if (ch_valid !== '0 || busy !== 1'b0 || err !== 1'b0 || ch_addr !== '0) begin
            miscompares++;
            $display("FAIL midreset_after: valid=%b busy=%b err=%b addr=%h, required 00 0 0 0", ch_valid, busy, err, ch_addr);
        end
    endtask

    task automatic test_backpressure;
        int t0;
        int nxt;
        int hit;
        bit ok;
        xstart = 27'h0123456; xstep = 27'h0001000; ystart = 27'h7F00000; ystep = 27'h7FFF000;
        push_frame(xstart, ystart, xstep, ystep);
        ch_ready = 2'b10; auto_en = 1'b1;
        start_frame(t0);
        tick(1);
        for (int c = 0; c < 20; c++) begin
            vectors++;
            if (ch_valid[0] !== 1'b1 || ch_addr[0 +: AW] !== exp_q[0].addr ||
                ch_cx[0 +: W] !== exp_q[0].cx || ch_cy[0 +: W] !== exp_q[0].cy) begin
                miscompares++;
                $display("FAIL bp_hold c%0d: v=%b addr=%0d cx=%h cy=%h, required v=1 addr=0 cx=%h cy=%h",
                         c, ch_valid[0], ch_addr[0 +: AW], ch_cx[0 +: W], ch_cy[0 +: W], exp_q[0].cx, exp_q[0].cy);
            end
            tick(1);
        end
        ch_ready = 2'b11;
        wait_done(40, ok);
        vectors++;
        if (!ok || done_cyc - t0 != 25 || frame_cycles !== 32'd24) begin
            miscompares++;
            $display("FAIL bp_done: done cycle %0d fc=%0d, required 25 and 24", done_cyc - t0, frame_cycles);
        end
        nxt = 1;
        foreach (obs_q[i]) begin
            hit = -1;
            foreach (exp_q[j]) if (hit < 0 && exp_q[j].addr === obs_q[i].addr) hit = j;
            vectors++;
            if (hit < 0) begin
                miscompares++;
                $display("FAIL bp_addr: got unexpected or duplicate addr %0d, required an unseen addr", obs_q[i].addr);
            end else begin
                if (obs_q[i].cx !== exp_q[hit].cx || obs_q[i].cy !== exp_q[hit].cy) begin
                    miscompares++;
                    $display("FAIL bp_coord addr %0d: cx=%h cy=%h, required cx=%h cy=%h",
                             obs_q[i].addr, obs_q[i].cx, obs_q[i].cy, exp_q[hit].cx, exp_q[hit].cy);
                end
                exp_q.delete(hit);
            end
            if (obs_q[i].ch == 1) begin
                vectors++;
                if (obs_q[i].addr !== AW'(nxt)) begin
                    miscompares++;
                    $display("FAIL bp_ch1_seq: got addr %0d, required %0d", obs_q[i].addr, nxt);
                end
                nxt++;
            end
        end
        vectors++;
        if (exp_q.size() != 0 || nxt != NPIX) begin
            miscompares++;
            $display("FAIL bp_coverage: %0d pixels never seen, ch1 count %0d, required 0 and %0d", exp_q.size(), nxt - 1, NPIX - 1);
        end
    endtask

    task automatic test_abort;
        int t0;
        bit ok;
        xstart = 27'h0200000; xstep = 27'h0000100; ystart = 27'h0000040; ystep = 27'h0000200;
        ch_ready = '1; auto_en = 1'b0;
        start_frame(t0);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        vectors++;
        if (ch_valid !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_next: valid=%b busy=%b, required 00 0", ch_valid, busy);
        end
        tick(3);
        vectors++;
        if (done_cnt != 0 || frame_cycles !== 32'd24 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet: done pulses=%0d fc=%0d err=%b, required 0 24 0", done_cnt, frame_cycles, err);
        end
        vectors++;
        if (obs_q.size() != 4) begin
            miscompares++;
            $display("FAIL abort_count: got %0d handshakes, required 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (obs_q[i].addr !== AW'(i)) begin
                    miscompares++;
                    $display("FAIL abort_seq: got addr %0d, required %0d", obs_q[i].addr, i);
                end
            end
        end
        xstart = 27'h0400000;
        auto_en = 1'b1;
        start_frame(t0);
        wait_done(40, ok);
        vectors++;
        if (!ok || obs_q.size() == 0 || obs_q[0].addr !== '0 || obs_q[0].cx !== 27'h0400000 ||
            obs_q[0].cy !== 27'h0000040 || frame_cycles !== 32'd15) begin
            miscompares++;
            $display("FAIL abort_restart: done=%0b n=%0d fc=%0d, required addr0 at cx=0400000 cy=0000040 and fc=15",
                     ok, obs_q.size(), frame_cycles);
        end
    endtask

    task automatic test_wrap_shadow;
        int t0;
        bit ok;
        pix_t e;
        xstart = 27'h7FFFFFF; xstep = 27'h0000001; ystart = 27'h0000010; ystep = 27'h0000100;
        push_frame(xstart, ystart, xstep, ystep);
        ch_ready = '1; auto_en = 1'b1;
        start_frame(t0);
        tick(2);
        xstart = 27'h1234567; xstep = 27'h0000055; ystep = 27'h0ABCDEF; ystart = 27'h0000777;
        wait_done(40, ok);
        vectors++;
        if (!ok || obs_q.size() != NPIX) begin
            miscompares++;
            $display("FAIL wrap_frame: done=%0b handshakes=%0d, required 1 and %0d", ok, obs_q.size(), NPIX);
        end else begin
            vectors++;
            if (obs_q[1].cx !== 27'h0000000 || obs_q[4].cx !== 27'h7FFFFFF) begin
                miscompares++;
                $display("FAIL wrap_cx: pix1 cx=%h pix4 cx=%h, required 0000000 7ffffff", obs_q[1].cx, obs_q[4].cx);
            end
            for (int i = 0; i < NPIX; i++) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_q[i].addr !== e.addr || obs_q[i].cx !== e.cx || obs_q[i].cy !== e.cy) begin
                    miscompares++;
                    $display("FAIL shadow_pix%0d: addr=%0d cx=%h cy=%h, required addr=%0d cx=%h cy=%h",
                             i, obs_q[i].addr, obs_q[i].cx, obs_q[i].cy, e.addr, e.cx, e.cy);
                end
            end
        end
    endtask

    task automatic test_error;
        int t0;
        bit ok;
        auto_en = 1'b0;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pre: got %b, required 0", err);
        end
        ret_man = 2'b01;
        tick(1);
        ret_man = '0;
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set: got %b, required 1", err);
        end
        tick(5);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b busy=%b, required 1 0", err, busy);
        end
        auto_en = 1'b1; ch_ready = '1;
        start_frame(t0);
        wait_done(40, ok);
        vectors++;
        if (!ok || done_cyc - t0 != 16 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_frame: done cycle %0d seen=%0b err=%b, required 16 1 1", done_cyc - t0, ok, err);
        end
    endtask

    initial begin
        tick(1);
        test_reset;
        test_frame;
        test_reset_midframe;
        test_backpressure;
        test_abort;
        test_wrap_shadow;
        test_error;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
